// File: rtl/uart_apb_sequencer.sv
// APB master that initialises a CoreUARTapb-style UART, then polls its status
// register and moves bytes between valid/ready streams and the UART data registers.
module uart_apb_sequencer #(
    parameter bit          FRAC_EN   = 1'b1,
    parameter int unsigned POLL_GAP  = 4,
    parameter bit          AUTO_INIT = 1'b1
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    output logic [4:0]  M_PADDR,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [7:0]  M_PWDATA,
    input  logic [7:0]  M_PRDATA,
    input  logic        M_PREADY,
    input  logic [12:0] cfg_baud,
    input  logic        cfg_bit8,
    input  logic        cfg_parity_en,
    input  logic        cfg_odd_n_even,
    input  logic [2:0]  cfg_frac,
    input  logic        cfg_start,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        err_parity,
    output logic        err_overflow,
    output logic        err_framing,
    input  logic        err_clr
);

    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [4:0] ADDR_TX     = 5'h00;
    localparam logic [4:0] ADDR_RX     = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CTRL3  = 5'h14;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT1, S_INIT2, S_INIT3, S_POLL, S_GAP, S_RDRX, S_WRTX
    } state_t;

    state_t             r_state;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_start_pend;
    logic               r_last_rx;
    logic [7:0]         r_tx_data;
    logic               r_tx_ready;
    logic               r_rx_valid;
    logic [7:0]         r_rx_data;
    logic               r_init_done;
    logic               r_err_parity;
    logic               r_err_overflow;
    logic               r_err_framing;
    logic [4:0]         r_paddr;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [7:0]         r_pwdata;

    logic               w_xfer_done;
    logic               w_poll_done;
    logic               w_reinit;
    logic               w_rx_elig;
    logic               w_tx_elig;
    logic               w_advance;
    state_t             w_next;
    logic [4:0]         w_paddr;
    logic               w_pwrite;
    logic [7:0]         w_pwdata;

    assign M_PADDR      = r_paddr;
    assign M_PSEL       = r_psel;
    assign M_PENABLE    = r_penable;
    assign M_PWRITE     = r_pwrite;
    assign M_PWDATA     = r_pwdata;
    assign tx_ready     = r_tx_ready;
    assign rx_valid     = r_rx_valid;
    assign rx_data      = r_rx_data;
    assign init_done    = r_init_done;
    assign err_parity   = r_err_parity;
    assign err_overflow = r_err_overflow;
    assign err_framing  = r_err_framing;

    // Next-state decision; only evaluated when the current step finishes.
    always_comb begin
        w_xfer_done = r_penable && M_PREADY;
        w_poll_done = (r_state == S_POLL) && w_xfer_done;
        w_reinit    = cfg_start || r_start_pend;
        w_rx_elig   = M_PRDATA[1] && !r_rx_valid;
        w_tx_elig   = M_PRDATA[0] && !r_tx_ready;
        w_advance   = 1'b0;
        w_next      = r_state;
        case (r_state)
            S_IDLE: begin
                if (AUTO_INIT || cfg_start) begin
                    w_advance = 1'b1;
                    w_next    = S_INIT1;
                end
            end
            S_INIT1: begin
                w_advance = w_xfer_done;
                w_next    = S_INIT2;
            end
            S_INIT2: begin
                w_advance = w_xfer_done;
                w_next    = FRAC_EN ? S_INIT3 : S_POLL;
            end
            S_INIT3, S_RDRX, S_WRTX: begin
                w_advance = w_xfer_done;
                w_next    = S_POLL;
            end
            S_POLL: begin
                w_advance = w_xfer_done;
                if (w_rx_elig && (!w_tx_elig || !r_last_rx)) w_next = S_RDRX;
                else if (w_tx_elig)                          w_next = S_WRTX;
                else if (POLL_GAP == 0)                      w_next = S_POLL;
                else                                         w_next = S_GAP;
            end
            S_GAP: begin
                w_advance = (r_gap_cnt == '0) || w_reinit;
                w_next    = S_POLL;
            end
            default: ;
        endcase
        // A pending re-init is honoured only at a step boundary, so no transfer is cut short.
        if (w_advance && w_reinit && (r_state != S_IDLE)) w_next = S_INIT1;

        w_paddr  = r_paddr;
        w_pwrite = r_pwrite;
        w_pwdata = r_pwdata;
        case (w_next)
            S_INIT1: begin
                w_paddr = ADDR_CTRL1;  w_pwrite = 1'b1; w_pwdata = cfg_baud[7:0];
            end
            S_INIT2: begin
                w_paddr  = ADDR_CTRL2; w_pwrite = 1'b1;
                w_pwdata = {cfg_baud[12:8], cfg_odd_n_even, cfg_parity_en, cfg_bit8};
            end
            S_INIT3: begin
                w_paddr = ADDR_CTRL3;  w_pwrite = 1'b1; w_pwdata = {5'b0, cfg_frac};
            end
            S_POLL:  begin w_paddr = ADDR_STATUS; w_pwrite = 1'b0; end
            S_RDRX:  begin w_paddr = ADDR_RX;     w_pwrite = 1'b0; end
            S_WRTX:  begin w_paddr = ADDR_TX;     w_pwrite = 1'b1; w_pwdata = r_tx_data; end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state        <= S_IDLE;
            r_gap_cnt      <= '0;
            r_start_pend   <= 1'b0;
            r_last_rx      <= 1'b0;
            r_tx_data      <= 8'h00;
            r_tx_ready     <= 1'b1;
            r_rx_valid     <= 1'b0;
            r_rx_data      <= 8'h00;
            r_init_done    <= 1'b0;
            r_err_parity   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_framing  <= 1'b0;
            r_paddr        <= 5'h00;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_pwrite       <= 1'b0;
            r_pwdata       <= 8'h00;
        end else begin
            if (tx_valid && r_tx_ready) begin
                r_tx_ready <= 1'b0;
                r_tx_data  <= tx_data;
            end
            if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

            // Sticky errors: a status read setting a flag beats a same-cycle clear.
            r_err_parity   <= (r_err_parity   && !err_clr) || (w_poll_done && M_PRDATA[2]);
            r_err_overflow <= (r_err_overflow && !err_clr) || (w_poll_done && M_PRDATA[3]);
            r_err_framing  <= (r_err_framing  && !err_clr) || (w_poll_done && M_PRDATA[4]);

            if (cfg_start && (r_state != S_IDLE)) r_start_pend <= 1'b1;
            if (r_psel && !r_penable) r_penable <= 1'b1;
            if ((r_state == S_GAP) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - GAP_W'(1);

            if (w_advance) begin
                r_state <= w_next;
                if (w_next == S_GAP) begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_gap_cnt <= GAP_W'(POLL_GAP - 1);
                end else begin
                    r_psel    <= 1'b1;
                    r_penable <= 1'b0;
                    r_paddr   <= w_paddr;
                    r_pwrite  <= w_pwrite;
                    r_pwdata  <= w_pwdata;
                end
                if (w_next == S_INIT1) begin
                    r_init_done  <= 1'b0;
                    r_start_pend <= 1'b0;
                end
                if ((w_next == S_POLL) && ((r_state == S_INIT2) || (r_state == S_INIT3)))
                    r_init_done <= 1'b1;
                if (r_state == S_RDRX) begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= M_PRDATA;
                    r_last_rx  <= 1'b1;
                end
                if (r_state == S_WRTX) begin
                    r_tx_ready <= 1'b1;
                    r_last_rx  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Self-checking bench: directed scenarios with random data and wait states,
// compared against a transaction-level model of the UART sequencer.
module tb_uart_apb_sequencer;

    localparam int POLL_GAP = 4;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic [4:0]  M_PADDR;
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [7:0]  M_PWDATA, M_PRDATA;
    logic        M_PREADY;
    logic [12:0] cfg_baud;
    logic        cfg_bit8, cfg_parity_en, cfg_odd_n_even;
    logic [2:0]  cfg_frac;
    logic        cfg_start;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        init_done, err_parity, err_overflow, err_framing, err_clr;

    uart_apb_sequencer #(.FRAC_EN(1'b1), .POLL_GAP(POLL_GAP), .AUTO_INIT(1'b1)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .M_PADDR(M_PADDR), .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
        .cfg_baud(cfg_baud), .cfg_bit8(cfg_bit8), .cfg_parity_en(cfg_parity_en),
        .cfg_odd_n_even(cfg_odd_n_even), .cfg_frac(cfg_frac), .cfg_start(cfg_start),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .init_done(init_done), .err_parity(err_parity), .err_overflow(err_overflow),
        .err_framing(err_framing), .err_clr(err_clr)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model of what the sequencer holds and owes the UART.
    logic       m_tx_full, m_rx_valid, m_last_rx;
    logic [7:0] m_tx_byte, m_rx_byte;
    logic [2:0] m_err;
    int         m_exp_idle;

    logic [4:0] a;
    logic       w;
    logic [7:0] d, b;
    int         idle, nacc;
    bit         found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Acts as the APB slave for one transfer; reports idle cycles before SETUP and ACCESS length.
    task automatic xfer(input int waits, input logic [7:0] rdata, input int start_at,
                        output logic [4:0] xa, output logic xw, output logic [7:0] xd,
                        output int xidle, output int xnacc);
        bit seen = 1'b0;
        xidle = 0;
        xnacc = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge PCLK);
            if (M_PSEL && !M_PENABLE) seen = 1'b1;
            else xidle++;
        end
        if (!seen) begin
            $display("FAIL apb_setup_timeout: observed no SETUP within 64 cycles, required one");
            $fatal(1, "bench stalled waiting for APB SETUP");
        end
        xa = M_PADDR; xw = M_PWRITE; xd = M_PWDATA;
        M_PRDATA = rdata;
        M_PREADY = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < waits; i++) begin
            if (M_PENABLE) xnacc++;
            cfg_start = (i == start_at);
            @(negedge PCLK);
            cfg_start = 1'b0;
        end
        if (M_PENABLE) xnacc++;
        chk("apb_stable", 32'({M_PADDR, M_PWRITE, M_PWDATA}), 32'({xa, xw, xd}));
        M_PREADY = 1'b1;
        @(posedge PCLK);
        #1;
        M_PREADY = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
        m_exp_idle -= n;
    endtask

    task automatic init_seq(input logic [12:0] baud, input logic b8, input logic p,
                            input logic o, input logic [2:0] fr);
        logic [4:0] ea [3];
        logic [7:0] ed [3];
        ea[0] = 5'h08; ea[1] = 5'h0C; ea[2] = 5'h14;
        ed[0] = 8'(32'(baud) % 256);
        ed[1] = 8'((32'(baud) / 256) * 8 + 32'(o) * 4 + 32'(p) * 2 + 32'(b8));
        ed[2] = 8'(fr);
        for (int k = 0; k < 3; k++) begin
            xfer(int'($urandom_range(0, 2)), 8'h00, -1, a, w, d, idle, nacc);
            chk("init_addr", 32'(a), 32'(ea[k]));
            chk("init_write", 32'(w), 32'd1);
            chk("init_data", 32'(d), 32'(ed[k]));
            chk("init_gap", 32'(idle), 32'((k == 0) ? m_exp_idle : 0));
            chk("init_done", 32'(init_done), 32'((k == 2) ? 1 : 0));
        end
        m_exp_idle = 0;
    endtask

    // One status poll plus whatever data transfer the model says it must trigger.
    task automatic step(input logic [7:0] status, input int waits);
        bit clr, rx_el, tx_el;
        clr = err_clr;
        xfer(waits, status, -1, a, w, d, idle, nacc);
        chk("poll_addr", 32'(a), 32'h10);
        chk("poll_write", 32'(w), 32'd0);
        chk("poll_gap", 32'(idle), 32'(m_exp_idle));
        chk("poll_access_len", 32'(nacc), 32'(waits + 1));
        m_err = (clr ? 3'b000 : m_err) | status[4:2];
        chk("err_flags", 32'({err_framing, err_overflow, err_parity}), 32'(m_err));
        rx_el = status[1] && !m_rx_valid;
        tx_el = status[0] && m_tx_full;
        m_exp_idle = 0;
        if (rx_el && (!tx_el || !m_last_rx)) begin
            b = 8'($urandom);
            xfer(int'($urandom_range(0, 2)), b, -1, a, w, d, idle, nacc);
            chk("rx_read_addr", 32'(a), 32'h04);
            chk("rx_read_write", 32'(w), 32'd0);
            chk("rx_read_gap", 32'(idle), 32'd0);
            chk("rx_valid_set", 32'(rx_valid), 32'd1);
            chk("rx_data", 32'(rx_data), 32'(b));
            m_last_rx  = 1'b1;
            m_rx_byte  = b;
            m_rx_valid = !rx_ready;
        end else if (tx_el) begin
            xfer(int'($urandom_range(0, 2)), 8'($urandom), -1, a, w, d, idle, nacc);
            chk("tx_write_addr", 32'(a), 32'h00);
            chk("tx_write_write", 32'(w), 32'd1);
            chk("tx_write_data", 32'(d), 32'(m_tx_byte));
            chk("tx_write_gap", 32'(idle), 32'd0);
            chk("tx_ready_after_write", 32'(tx_ready), 32'd1);
            m_last_rx = 1'b0;
            m_tx_full = 1'b0;
            if (tx_valid) begin
                tx_data   = 8'($urandom);
                m_tx_byte = tx_data;
                m_tx_full = 1'b1;
            end
        end else begin
            m_exp_idle = POLL_GAP;
        end
    endtask

    initial begin
        PRESETN = 1'b0;
        M_PRDATA = 8'h00; M_PREADY = 1'b0;
        cfg_baud = 13'h1A5; cfg_bit8 = 1'b1; cfg_parity_en = 1'b1; cfg_odd_n_even = 1'b0;
        cfg_frac = 3'd3; cfg_start = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;
        m_tx_full = 1'b0; m_rx_valid = 1'b0; m_last_rx = 1'b0; m_err = 3'b000;
        m_tx_byte = 8'h00; m_rx_byte = 8'h00;

        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_psel", 32'(M_PSEL), 32'd0);
        chk("rst_penable", 32'(M_PENABLE), 32'd0);
        chk("rst_pwrite", 32'(M_PWRITE), 32'd0);
        chk("rst_paddr", 32'(M_PADDR), 32'd0);
        chk("rst_pwdata", 32'(M_PWDATA), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx", 32'({rx_valid, rx_data}), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'({err_framing, err_overflow, err_parity}), 32'd0);

        // Released mid-cycle: one IDLE cycle, then the CTRL1 write.
        PRESETN = 1'b1;
        m_exp_idle = 1;
        init_seq(13'h1A5, 1'b1, 1'b1, 1'b0, 3'd3);

        step(8'h00, 0);
        b = 8'($urandom);
        tx_valid = 1'b1; tx_data = b;
        cycles(1);
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", 32'(tx_ready), 32'd0);
        m_tx_full = 1'b1; m_tx_byte = b;
        step(8'h01, 1);

        rx_ready = 1'b0;
        step(8'h02, 0);
        step(8'h02, 2);
        chk("rx_held_valid", 32'(rx_valid), 32'd1);
        chk("rx_held_data", 32'(rx_data), 32'(m_rx_byte));
        rx_ready = 1'b1;
        cycles(1);
        chk("rx_consumed", 32'(rx_valid), 32'd0);
        m_rx_valid = 1'b0;

        // Keep the TX side always offering and RX always accepting from here on.
        tx_data = 8'($urandom);
        tx_valid = 1'b1;
        cycles(1);
        if (!m_tx_full) begin
            m_tx_full = 1'b1;
            m_tx_byte = tx_data;
        end
        for (int i = 0; i < 6; i++) step(8'h03, int'($urandom_range(0, 2)));
        for (int i = 0; i < 12; i++)
            step(8'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        err_clr = 1'b1;
        step(8'h18, 0);
        chk("err_set_wins", 32'({err_framing, err_overflow}), 32'd3);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        m_err = 3'b000;
        chk("err_cleared", 32'({err_framing, err_overflow, err_parity}), 32'd0);

        cfg_baud = 13'($urandom); cfg_bit8 = 1'($urandom); cfg_parity_en = 1'($urandom);
        cfg_odd_n_even = 1'($urandom); cfg_frac = 3'($urandom);
        xfer(3, 8'h00, 1, a, w, d, idle, nacc);
        chk("restart_poll_addr", 32'(a), 32'h10);
        chk("restart_poll_gap", 32'(idle), 32'(m_exp_idle));
        chk("restart_access_len", 32'(nacc), 32'd4);
        chk("restart_init_dropped", 32'(init_done), 32'd0);
        m_exp_idle = 0;
        init_seq(cfg_baud, cfg_bit8, cfg_parity_en, cfg_odd_n_even, cfg_frac);
        step(8'h01, 0);

        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge PCLK);
            if (M_PSEL) found = 1'b1;
        end
        chk("pre_reset_busy", 32'(M_PSEL), 32'd1);
        PRESETN = 1'b0;
        #1;
        chk("async_rst_psel", 32'({M_PSEL, M_PENABLE}), 32'd0);
        chk("async_rst_paddr", 32'(M_PADDR), 32'd0);
        chk("async_rst_status", 32'({init_done, tx_ready, rx_valid}), 32'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
